// File: rtl/universal_register.sv
// Parametrised multi-mode register: load, shift, rotate, increment and decrement with carry/zero flags.
// Build option: define UREG_SATURATE_EN to make INC/DEC saturate instead of wrapping.
module universal_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             carry,
    output logic             zero
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_INC  = 3'b110;
    localparam logic [2:0] MODE_DEC  = 3'b111;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    // Each helper returns {carry, data} computed from the pre-op contents.
    function automatic logic [WIDTH:0] inc_op(input logic [WIDTH-1:0] d);
        logic [WIDTH:0] sum;
        sum = {1'b0, d} + {1'b0, ONE};
`ifdef UREG_SATURATE_EN
        if (d == ALL_ONES)
            sum = {1'b1, ALL_ONES};
`endif
        return sum;
    endfunction

    function automatic logic [WIDTH:0] dec_op(input logic [WIDTH-1:0] d);
        logic             borrow;
        logic [WIDTH-1:0] diff;
        borrow = (d == '0);
        diff   = d - ONE;
`ifdef UREG_SATURATE_EN
        if (borrow)
            diff = '0;
`endif
        return {borrow, diff};
    endfunction

    function automatic logic [WIDTH:0] shift_op(input logic [2:0] m,
                                                input logic [WIDTH-1:0] d,
                                                input logic s);
        logic [WIDTH:0] res;
        case (m)
            MODE_SHL: res = {d[WIDTH-1], d[WIDTH-2:0], s};
            MODE_SHR: res = {d[0], s, d[WIDTH-1:1]};
            MODE_ROL: res = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
            default:  res = {d[0], d[0], d[WIDTH-1:1]};
        endcase
        return res;
    endfunction

    logic [WIDTH-1:0] next_dout;
    logic             next_carry;

    always_comb begin
        next_dout  = dout;
        next_carry = carry;
        case (mode)
            MODE_HOLD: begin
                next_dout  = dout;
                next_carry = carry;
            end
            MODE_LOAD: begin
                next_dout  = din;
                next_carry = 1'b0;
            end
            MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR:
                {next_carry, next_dout} = shift_op(mode, dout, sin);
            MODE_INC:
                {next_carry, next_dout} = inc_op(dout);
            MODE_DEC:
                {next_carry, next_dout} = dec_op(dout);
            default: begin
                next_dout  = dout;
                next_carry = carry;
            end
        endcase
    end

    // Priority: async reset, then synchronous clear, then enabled operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout  <= RESET_VALUE;
            carry <= 1'b0;
        end else if (clr) begin
            dout  <= RESET_VALUE;
            carry <= 1'b0;
        end else if (en) begin
            dout  <= next_dout;
            carry <= next_carry;
        end
    end

    assign zero = (dout == '0);

endmodule

// File: tb/tb_universal_register.sv
// Self-checking bench for universal_register (WIDTH=8): directed scenarios plus random ops against an integer model.
module tb_universal_register;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         clr;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] din;
    logic         sin;
    logic [W-1:0] dout;
    logic         carry;
    logic         zero;

    int checks;
    int errors;

    universal_register #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (en),
        .mode  (mode),
        .din   (din),
        .sin   (sin),
        .dout  (dout),
        .carry (carry),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, let one rising edge sample them, then sample outputs 1 time unit later.
    task automatic step(input logic c, input logic e, input logic [2:0] m,
                        input logic [W-1:0] d, input logic s);
        clr  = c;
        en   = e;
        mode = m;
        din  = d;
        sin  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clr = 1'b0; en = 1'b0; mode = 3'b000; din = '0; sin = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (dout !== 8'h00 || carry !== 1'b0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL power_on_reset dout=%h carry=%b zero=%b expected 00 0 1", dout, carry, zero);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        step(1'b0, 1'b1, 3'b001, 8'h5A, 1'b0);
        checks++;
        if (dout !== 8'h5A) begin
            errors++;
            $display("FAIL first_op_after_reset dout=%h expected 5a", dout);
        end
        // Assert reset between edges: outputs must clear before the next edge.
        #2 reset = 1'b0;
        #1;
        checks++;
        if (dout !== 8'h00 || carry !== 1'b0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL midstream_reset dout=%h carry=%b zero=%b expected 00 0 1", dout, carry, zero);
        end
        en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_load_hold();
        step(1'b0, 1'b1, 3'b001, 8'hA5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));
            checks++;
            if (dout !== 8'hA5 || carry !== 1'b0 || zero !== 1'b0) begin
                errors++;
                $display("FAIL load_hold[%0d] dout=%h carry=%b zero=%b expected a5 0 0", i, dout, carry, zero);
            end
        end
    endtask

    task automatic test_shift_rotate();
        step(1'b0, 1'b1, 3'b001, 8'h81, 1'b0);
        step(1'b0, 1'b1, 3'b010, 8'h00, 1'b0);
        checks++;
        if (dout !== 8'h02 || carry !== 1'b1) begin
            errors++;
            $display("FAIL shl dout=%h carry=%b expected 02 1", dout, carry);
        end
        step(1'b0, 1'b1, 3'b101, 8'h00, 1'b0);
        checks++;
        if (dout !== 8'h01 || carry !== 1'b0) begin
            errors++;
            $display("FAIL ror dout=%h carry=%b expected 01 0", dout, carry);
        end
        step(1'b0, 1'b1, 3'b011, 8'h00, 1'b1);
        checks++;
        if (dout !== 8'h80 || carry !== 1'b1) begin
            errors++;
            $display("FAIL shr dout=%h carry=%b expected 80 1", dout, carry);
        end
        step(1'b0, 1'b1, 3'b100, 8'h00, 1'b0);
        checks++;
        if (dout !== 8'h01 || carry !== 1'b1) begin
            errors++;
            $display("FAIL rol dout=%h carry=%b expected 01 1", dout, carry);
        end
    endtask

    task automatic test_inc_dec();
        step(1'b0, 1'b1, 3'b001, 8'hFF, 1'b0);
        step(1'b0, 1'b1, 3'b110, 8'h00, 1'b0);
`ifdef UREG_SATURATE_EN
        checks++;
        if (dout !== 8'hFF || carry !== 1'b1 || zero !== 1'b0) begin
            errors++;
            $display("FAIL inc_saturate dout=%h carry=%b zero=%b expected ff 1 0", dout, carry, zero);
        end
        step(1'b0, 1'b1, 3'b001, 8'h00, 1'b0);
        step(1'b0, 1'b1, 3'b111, 8'h00, 1'b0);
        checks++;
        if (dout !== 8'h00 || carry !== 1'b1 || zero !== 1'b1) begin
            errors++;
            $display("FAIL dec_saturate dout=%h carry=%b zero=%b expected 00 1 1", dout, carry, zero);
        end
`else
        checks++;
        if (dout !== 8'h00 || carry !== 1'b1 || zero !== 1'b1) begin
            errors++;
            $display("FAIL inc_wrap dout=%h carry=%b zero=%b expected 00 1 1", dout, carry, zero);
        end
        step(1'b0, 1'b1, 3'b111, 8'h00, 1'b0);
        checks++;
        if (dout !== 8'hFF || carry !== 1'b1 || zero !== 1'b0) begin
            errors++;
            $display("FAIL dec_wrap dout=%h carry=%b zero=%b expected ff 1 0", dout, carry, zero);
        end
`endif
        step(1'b0, 1'b1, 3'b001, 8'h41, 1'b0);
        step(1'b0, 1'b1, 3'b110, 8'h00, 1'b0);
        checks++;
        if (dout !== 8'h42 || carry !== 1'b0) begin
            errors++;
            $display("FAIL inc_plain dout=%h carry=%b expected 42 0", dout, carry);
        end
        step(1'b0, 1'b1, 3'b111, 8'h00, 1'b0);
        step(1'b0, 1'b1, 3'b111, 8'h00, 1'b0);
        checks++;
        if (dout !== 8'h40 || carry !== 1'b0) begin
            errors++;
            $display("FAIL dec_chain dout=%h carry=%b expected 40 0", dout, carry);
        end
    endtask

    task automatic test_clr();
        step(1'b0, 1'b1, 3'b001, 8'hFF, 1'b0);
        step(1'b0, 1'b1, 3'b110, 8'h00, 1'b0);
        step(1'b1, 1'b1, 3'b001, 8'h3C, 1'b0);
        checks++;
        if (dout !== 8'h00 || carry !== 1'b0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL clr_over_en dout=%h carry=%b zero=%b expected 00 0 1", dout, carry, zero);
        end
        step(1'b0, 1'b1, 3'b001, 8'h77, 1'b0);
        step(1'b1, 1'b0, 3'b000, 8'h00, 1'b0);
        checks++;
        if (dout !== 8'h00 || carry !== 1'b0) begin
            errors++;
            $display("FAIL clr_without_en dout=%h carry=%b expected 00 0", dout, carry);
        end
    endtask

    task automatic test_random();
        int m;
        int mc;
        int s;
        logic         c_r, e_r, s_r;
        logic [2:0]   m_r;
        logic [W-1:0] d_r;
        step(1'b1, 1'b0, 3'b000, 8'h00, 1'b0);
        m  = 0;
        mc = 0;
        for (int i = 0; i < 2000; i++) begin
            c_r = ($urandom_range(0, 15) == 0);
            e_r = ($urandom_range(0, 3) != 0);
            m_r = 3'($urandom_range(0, 7));
            d_r = 8'($urandom);
            s_r = 1'($urandom);
            if (e_r && $isunknown(m_r)) begin
                errors++;
                $display("FAIL mode_unknown cycle=%0d mode=%b expected known value", i, m_r);
            end
            step(c_r, e_r, m_r, d_r, s_r);
            if (c_r) begin
                m = 0; mc = 0;
            end else if (e_r) begin
                case (m_r)
                    3'd1: begin m = d_r; mc = 0; end
                    3'd2: begin mc = m / 128; m = (m * 2 + s_r) % 256; end
                    3'd3: begin mc = m % 2; m = m / 2 + s_r * 128; end
                    3'd4: begin mc = m / 128; m = (m * 2) % 256 + m / 128; end
                    3'd5: begin mc = m % 2; m = m / 2 + (m % 2) * 128; end
                    3'd6: begin
                        s = m + 1;
                        mc = (s > 255) ? 1 : 0;
`ifdef UREG_SATURATE_EN
                        m = (s > 255) ? 255 : s;
`else
                        m = s % 256;
`endif
                    end
                    3'd7: begin
                        mc = (m == 0) ? 1 : 0;
`ifdef UREG_SATURATE_EN
                        m = (m == 0) ? 0 : m - 1;
`else
                        m = (m + 255) % 256;
`endif
                    end
                    default: ;
                endcase
            end
            checks++;
            if (dout !== 8'(m) || carry !== 1'(mc) || zero !== (m == 0)) begin
                errors++;
                $display("FAIL random cycle=%0d mode=%0d en=%b clr=%b dout=%h carry=%b zero=%b expected %h %0d %0d",
                         i, m_r, e_r, c_r, dout, carry, zero, m[7:0], mc, (m == 0));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_hold();
        test_shift_rotate();
        test_inc_dec();
        test_clr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
